iq_mixer_cic: RTL

//   Quadrature downconverter + decimator directly downstream of nco_sig. Mixes the 1-bit RF

---
 rtl/iq_mixer_cic.sv | 136 +++++++++++++
 1 files changed

// File: rtl/iq_mixer_cic.sv
// iq_mixer_cic: 1-bit RF x square-wave LO quadrature mixer followed by a per-channel
// STAGES-order CIC decimator (R = 2**DECIM_LOG2) with a one-cycle output strobe.
// Optional build macro IQ_MIXER_CIC_ROUND_EN: round-half-up with positive saturation
// before truncation; without it the output is a plain floor of the top bits.
module iq_mixer_cic #(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned DECIM_LOG2 = 8,
  parameter int unsigned OUT_WIDTH  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rf_in,
  input  logic                        sinewave_in,
  input  logic                        cosinewave_in,
  output logic signed [OUT_WIDTH-1:0] i_out,
  output logic signed [OUT_WIDTH-1:0] q_out,
  output logic                        out_valid
);

  localparam int unsigned FullW = STAGES * DECIM_LOG2 + 2;
  localparam int unsigned Shift = FullW - OUT_WIDTH;

  typedef logic [FullW-1:0] word_t;

`ifdef IQ_MIXER_CIC_ROUND_EN
  // Half an output LSB; collapses to zero when no bits are dropped.
  localparam logic [FullW:0] RndHalf = (FullW + 1)'((64'd1 << Shift) >> 1);
`endif

  // Keep the top OUT_WIDTH bits of a comb result.
  function automatic logic [OUT_WIDTH-1:0] scale(input word_t y);
`ifdef IQ_MIXER_CIC_ROUND_EN
    logic [FullW:0] sum;
    // One guard bit so a rounding carry out of the positive range is visible.
    sum = {y[FullW-1], y} + RndHalf;
    if (!sum[FullW] && sum[FullW-1]) begin
      return {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end
    return OUT_WIDTH'($signed(sum) >>> Shift);
`else
    return OUT_WIDTH'($signed(y) >>> Shift);
`endif
  endfunction

  // RF synchroniser and matching LO delay line; bit [1] is the aligned output.
  logic [1:0] rf_sync_q, sin_dly_q, cos_dly_q;
  // Mixer outputs as 2-bit two's complement: 01 = +1, 11 = -1, 00 only out of reset.
  logic [1:0] i_mix_q, q_mix_q, i_mix_d, q_mix_d;

  word_t i_integ_q [STAGES];
  word_t i_integ_d [STAGES];
  word_t q_integ_q [STAGES];
  word_t q_integ_d [STAGES];
  word_t i_dly_q   [STAGES];
  word_t i_dly_d   [STAGES];
  word_t q_dly_q   [STAGES];
  word_t q_dly_d   [STAGES];

  logic [DECIM_LOG2-1:0] dec_cnt_q, dec_cnt_d;
  logic                  tick;
  logic [OUT_WIDTH-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;
  logic                  valid_q, valid_d;

  assign tick      = &dec_cnt_q;
  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = valid_q;

  // Next state: mixer, integrator cascade, decimated comb chain and output scaling.
  always_comb begin
    word_t i_x;
    word_t q_x;
    i_mix_d   = (rf_sync_q[1] ^ cos_dly_q[1]) ? 2'b11 : 2'b01;
    q_mix_d   = (rf_sync_q[1] ^ sin_dly_q[1]) ? 2'b11 : 2'b01;
    dec_cnt_d = dec_cnt_q + DECIM_LOG2'(1);

    i_integ_d[0] = i_integ_q[0] + {{(FullW - 2){i_mix_q[1]}}, i_mix_q};
    q_integ_d[0] = q_integ_q[0] + {{(FullW - 2){q_mix_q[1]}}, q_mix_q};
    for (int k = 1; k < STAGES; k++) begin
      i_integ_d[k] = i_integ_q[k] + i_integ_q[k-1];
      q_integ_d[k] = q_integ_q[k] + q_integ_q[k-1];
    end

    // Comb stages only advance on tick; between ticks the delays hold.
    i_x = i_integ_q[STAGES-1];
    q_x = q_integ_q[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      i_dly_d[k] = tick ? i_x : i_dly_q[k];
      q_dly_d[k] = tick ? q_x : q_dly_q[k];
      i_x        = i_x - i_dly_q[k];
      q_x        = q_x - q_dly_q[k];
    end

    i_out_d = tick ? scale(i_x) : i_out_q;
    q_out_d = tick ? scale(q_x) : q_out_q;
    valid_d = tick;
  end

  // State registers; reset discards all filter history at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_sync_q <= '0;
      sin_dly_q <= '0;
      cos_dly_q <= '0;
      i_mix_q   <= '0;
      q_mix_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        i_integ_q[k] <= '0;
        q_integ_q[k] <= '0;
        i_dly_q[k]   <= '0;
        q_dly_q[k]   <= '0;
      end
      dec_cnt_q <= '0;
      i_out_q   <= '0;
      q_out_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      rf_sync_q <= {rf_sync_q[0], rf_in};
      sin_dly_q <= {sin_dly_q[0], sinewave_in};
      cos_dly_q <= {cos_dly_q[0], cosinewave_in};
      i_mix_q   <= i_mix_d;
      q_mix_q   <= q_mix_d;
      for (int k = 0; k < STAGES; k++) begin
        i_integ_q[k] <= i_integ_d[k];
        q_integ_q[k] <= q_integ_d[k];
        i_dly_q[k]   <= i_dly_d[k];
        q_dly_q[k]   <= q_dly_d[k];
      end
      dec_cnt_q <= dec_cnt_d;
      i_out_q   <= i_out_d;
      q_out_q   <= q_out_d;
      valid_q   <= valid_d;
    end
  end

endmodule
